// File: rtl/prefix_adder_pipe.sv
// prefix_adder_pipe: pipelined Kogge-Stone add/sub with valid/ready and a sideband tag.
// Define PREFIX_ADDER_PIPE_STATS_EN to add the op_count/stall_count outputs.
module prefix_adder_pipe #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [TAG_W-1:0] out_tag
`ifdef PREFIX_ADDER_PIPE_STATS_EN
  ,
  output logic [31:0]      op_count,
  output logic [31:0]      stall_count
`endif
);

  localparam int LG = $clog2(WIDTH);
  localparam int NG = (LG + REG_EVERY - 1) / REG_EVERY;

  logic                        advance;
  logic [NG:0]                 v;
  logic [NG:0][WIDTH-1:0]      rg;
  logic [NG-1:0][WIDTH-1:0]    rp;
  logic [NG:0][WIDTH-1:0]      rx;
  logic [NG:0]                 rc;
  logic [NG:0]                 rsa;
  logic [NG:0]                 rsb;
  logic [NG:0][TAG_W-1:0]      rt;

  logic [NG:0][WIDTH-1:0]      gin;
  logic [NG-1:0][WIDTH-1:0]    pin;

  logic [WIDTH-1:0] bm;
  logic [WIDTH-1:0] g0;
  logic [WIDTH-1:0] p0;
  logic             c0;

  // Bit 0 absorbs the carry-in so the prefix tree needs no extra column.
  always_comb begin
    bm    = sub ? ~b : b;
    c0    = sub | cin;
    g0    = a & bm;
    p0    = a | bm;
    g0[0] = (a[0] & bm[0]) | (a[0] & c0) | (bm[0] & c0);
    p0[0] = g0[0];
  end

  assign gin[0] = g0;
  assign pin[0] = p0;

  for (genvar l = 0; l < LG; l++) begin : g_lvl
    localparam int D = 1 << l;
    logic [WIDTH-1:0] gi;
    logic [WIDTH-1:0] pi;
    logic [WIDTH-1:0] go;
    if (l % REG_EVERY == 0) begin : g_head
      assign gi = rg[l / REG_EVERY];
      assign pi = rp[l / REG_EVERY];
    end else begin : g_mid
      assign gi = g_lvl[l-1].go;
      assign pi = g_lvl[l-1].g_p.po;
    end
    assign go = gi | (pi & {gi[WIDTH-1-D:0], {D{1'b0}}});
    if (l < LG - 1) begin : g_p
      logic [WIDTH-1:0] po;
      assign po = pi & {pi[WIDTH-1-D:0], {D{1'b1}}};
    end
  end

  for (genvar i = 0; i < NG; i++) begin : g_grp
    localparam int LAST =
      ((i + 1) * REG_EVERY < LG) ? (i + 1) * REG_EVERY - 1 : LG - 1;
    assign gin[i+1] = g_lvl[LAST].go;
    if (i < NG - 1) begin : g_pp
      assign pin[i+1] = g_lvl[LAST].g_p.po;
    end
  end

  assign out_valid = v[NG];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;

  // Global stall: every stage, bubbles included, moves only on advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v   <= '0;
      rg  <= '0;
      rp  <= '0;
      rx  <= '0;
      rc  <= '0;
      rsa <= '0;
      rsb <= '0;
      rt  <= '0;
    end else if (advance) begin
      v   <= {v[NG-1:0], in_valid};
      rg  <= gin;
      rp  <= pin;
      rx  <= {rx[NG-1:0], a ^ bm};
      rc  <= {rc[NG-1:0], c0};
      rsa <= {rsa[NG-1:0], a[WIDTH-1]};
      rsb <= {rsb[NG-1:0], bm[WIDTH-1]};
      rt  <= {rt[NG-1:0], in_tag};
    end
  end

  assign sum     = rx[NG] ^ {rg[NG][WIDTH-2:0], rc[NG]};
  assign cout    = rg[NG][WIDTH-1];
  assign ovf     = (rsa[NG] == rsb[NG]) & (sum[WIDTH-1] != rsa[NG]);
  assign out_tag = rt[NG];

`ifdef PREFIX_ADDER_PIPE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (out_valid & out_ready)
        op_count <= op_count + 32'd1;
      if (out_valid & ~out_ready & (stall_count != '1))
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/prefix_adder_pipe.md
Name: prefix_adder_pipe

Overview:
- Parametrised, pipelined successor to the team's 32-bit recursive-doubling (Kogge-Stone) carry-lookahead adder.
- Computes A+B+cin or A-B over WIDTH bits. The log2(WIDTH) prefix levels are split into register groups.
- Carries operands through a valid/ready pipeline with a sideband tag.
- Sits in the Wallace-multiplier datapath as the final carry-propagate adder and as a standalone ALU adder.

Parameters:
- WIDTH, 32, operand width; power of two, 4..64.
- REG_EVERY, 2, prefix levels per pipeline register group; 1..log2(WIDTH).
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block accepts the operand this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  1 = compute A-B.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB.
- ovf  out  1  signed overflow.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Reset values while reset=1, applied asynchronously:
  - out_valid=0, sum=0, cout=0, ovf=0, out_tag=0.
  - All internal valid bits are cleared.
  - in_ready=1 once reset deasserts.
- Reset mid-operation discards all in-flight operations; none are emitted afterwards.
- Stage 0 (input register), on acceptance (in_valid & in_ready):
  - b' = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
  - Register g=a&b', p=a|b' and x=a^b', with bit 0 folded with c0 as g0=maj(a0,b'0,c0), p0=g0.
  - Register tag and the sign bits a[MSB] and b'[MSB].
- Prefix stages, with distance d doubling 1,2,4,...,WIDTH/2:
  - For j>=d: G[j] = G[j]|(P[j]&G[j-d]) and P[j] = P[j]&P[j-d]. Positions j<d pass through.
  - A pipeline register follows every REG_EVERY levels and after the last level.
- Output:
  - sum[0] = x[0]^c0; sum[i] = x[i]^G[i-1] for i>=1.
  - cout = G[WIDTH-1].
  - ovf = (a[MSB]==b'[MSB]) & (sum[MSB]!=a[MSB]).
  - The output register is the final group register, with sum, cout and ovf decoded combinationally from it and held stable.
- Latency LAT = 1 + ceil(log2(WIDTH)/REG_EVERY) cycles from acceptance to out_valid, absent stall.
  - Defaults: LAT = 1+ceil(5/2) = 4.
- Handshake: global stall.
  - advance = ~out_valid | out_ready; in_ready = advance.
  - When advance=0, every stage holds, bubbles included.
  - out_valid and the output payload stay stable until out_ready=1.
- Throughput: one operation per cycle when out_ready is held high.
- Ordering: results emerge in acceptance order.
- Width rules: all arithmetic is modulo 2^WIDTH, and the carry into the MSB+1 is reported on cout.
- Subtract with borrow: cout=1 means no borrow (A>=B unsigned).
- Simultaneous in_valid & out_valid with out_ready=1: one result leaves and one operand enters in the same cycle.
- Simultaneous in_valid & out_valid with out_ready=0: nothing moves.

Optional Feature:
- PREFIX_ADDER_PIPE_STATS_EN:
  - Adds output op_count (32 bits): counts output handshakes (out_valid & out_ready), wraps at 2^32, resets to 0.
  - Adds output stall_count (32 bits): counts cycles with out_valid & ~out_ready, saturates at 2^32-1, resets to 0.
- Without the macro:
  - Neither port exists.
  - No counter logic is generated, and all other behaviour is identical.

Test Plan:
- WIDTH=32, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, out_ready=1 -> after 4 cycles sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, ovf=1; a=0x00000005, b=0x00000007, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Back-to-back stream of 8 ops with tags 0..7, out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4, tags in order 0..7.
- Stall: out_ready=0 for 5 cycles while results are pending:
  - in_ready=0 for those cycles and sum/out_tag are held.
  - After release, no op is lost or duplicated.
- Reset asserted for 1 cycle with 3 ops in flight -> out_valid=0 immediately, and no stale result after reset.
- Random regression over WIDTH in {8,16,64} and REG_EVERY in {1,2,log2(WIDTH)}, 10k ops with random out_ready against a behavioural a+b+cin model:
  - Results and latency match 1+ceil(log2(WIDTH)/REG_EVERY).
  - With PREFIX_ADDER_PIPE_STATS_EN, op_count equals the number of output handshakes.
